// File: rtl/bus_id_checker_pkg.sv
// Shared definitions for the ID/version self-test master and the ConstReg
// slave it reads.
//   state_t      : master sequencer states
//   idx_t        : register index (0..2) within the ID block
//   DEF_*        : default ID block base address, expected contents and
//                  default ack timeout
package bus_id_checker_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef logic [1:0] idx_t;

  localparam logic [31:0] DEF_BASE_ADDR   = 32'h0200_0100;
  localparam logic [31:0] DEF_VER1        = 32'h0123_4567;
  localparam logic [31:0] DEF_VER2        = 32'h89AB_CDEF;
  localparam logic [31:0] DEF_VER3        = 32'hFEDC_BA98;
  localparam int          DEF_TIMEOUT_CYC = 8;

  localparam idx_t LAST_IDX = 2'd2;

endpackage

// File: rtl/bus_id_checker.sv
// bus_id_checker: on a start pulse, reads the three constant ID/version
// registers over a single-master strobe/ack bus and compares each word to its
// expected value. Stops at the first mismatch or ack timeout.
// Ports:
//   iCLK, iRST       clock, asynchronous active-high reset
//   iSTART           start request (only honoured in IDLE)
//   oADR/oSTB/oWE    bus request (oWE tied low, read-only master)
//   iDAT/iACK        bus response; iACK may be combinational on oSTB
//   oBUSY            high whenever the sequencer is not IDLE
//   oDONE            one-cycle completion pulse
//   oPASS            all three words matched
//   oTIMEOUT         run aborted because ack never came
//   oERR_IDX         index of the first mismatch/timeout, 0 on pass
//   oLAST_DAT        last word captured with ack
module bus_id_checker
  import bus_id_checker_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
  parameter logic [31:0] EXP_VER1    = DEF_VER1,
  parameter logic [31:0] EXP_VER2    = DEF_VER2,
  parameter logic [31:0] EXP_VER3    = DEF_VER3,
  parameter int          TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iSTART,
  output logic [31:0] oADR,
  input  logic [31:0] iDAT,
  output logic        oSTB,
  output logic        oWE,
  input  logic        iACK,
  output logic        oBUSY,
  output logic        oDONE,
  output logic        oPASS,
  output logic        oTIMEOUT,
  output logic [1:0]  oERR_IDX,
  output logic [31:0] oLAST_DAT
);

  localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);
  // Value of the wait counter on the last strobe cycle before giving up, so
  // that oSTB is held for exactly TIMEOUT_CYC cycles.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYC - 1);

  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("bus_id_checker: TIMEOUT_CYC must be at least 1");
  end

  state_t            state;
  idx_t              idx;
  logic [WAIT_W-1:0] wait_cnt;

  function automatic logic [31:0] expected(input idx_t k);
    case (k)
      2'd0:    expected = EXP_VER1;
      2'd1:    expected = EXP_VER2;
      default: expected = EXP_VER3;
    endcase
  endfunction

  // Bus request decoded from registered state/index only; reset therefore
  // drops the strobe asynchronously.
  assign oSTB  = (state == REQ);
  assign oADR  = oSTB ? (BASE_ADDR + {28'd0, idx, 2'b00}) : 32'd0;
  assign oWE   = 1'b0;
  assign oBUSY = (state != IDLE);
  assign oDONE = (state == DONE);

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state     <= IDLE;
      idx       <= '0;
      wait_cnt  <= '0;
      oPASS     <= 1'b0;
      oTIMEOUT  <= 1'b0;
      oERR_IDX  <= '0;
      oLAST_DAT <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (iSTART) begin
            oPASS     <= 1'b0;
            oTIMEOUT  <= 1'b0;
            oERR_IDX  <= '0;
            oLAST_DAT <= '0;
            idx       <= '0;
            wait_cnt  <= '0;
            state     <= REQ;
          end
        end
        REQ: begin
          // Ack wins over a timeout expiring in the same cycle.
          if (iACK) begin
            oLAST_DAT <= iDAT;
            if (iDAT != expected(idx)) begin
              oERR_IDX <= idx;
              state    <= DONE;
            end else if (idx == LAST_IDX) begin
              oPASS <= 1'b1;
              state <= DONE;
            end else begin
              idx   <= idx + 2'd1;
              state <= GAP;
            end
          end else if (wait_cnt >= WAIT_LAST) begin
            oTIMEOUT <= 1'b1;
            oERR_IDX <= idx;
            state    <= DONE;
          end else begin
            // Never passes WAIT_LAST, so the counter cannot wrap.
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        GAP: begin
          wait_cnt <= '0;
          state    <= REQ;
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_id_checker.sv
module tb_bus_id_checker;
  import bus_id_checker_pkg::*;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b0;
  logic        iSTART = 1'b0;
  logic [31:0] oADR;
  logic [31:0] iDAT;
  logic        oSTB;
  logic        oWE;
  logic        iACK;
  logic        oBUSY;
  logic        oDONE;
  logic        oPASS;
  logic        oTIMEOUT;
  logic [1:0]  oERR_IDX;
  logic [31:0] oLAST_DAT;

  int errors = 0;
  int checks = 0;

  bus_id_checker dut (
    .iCLK(iCLK), .iRST(iRST), .iSTART(iSTART),
    .oADR(oADR), .iDAT(iDAT), .oSTB(oSTB), .oWE(oWE), .iACK(iACK),
    .oBUSY(oBUSY), .oDONE(oDONE), .oPASS(oPASS), .oTIMEOUT(oTIMEOUT),
    .oERR_IDX(oERR_IDX), .oLAST_DAT(oLAST_DAT)
  );

  always #5 iCLK = ~iCLK;

  // Slave model: ConstReg contents with optional corruption, ack delay and
  // a never-acked address.
  int          ack_delay = 0;
  logic [31:0] noack_adr = 32'hFFFF_FFFF;
  logic [31:0] bad_adr   = 32'hFFFF_FFFF;
  logic [31:0] bad_val   = 32'd0;
  int          stb_cnt   = 0;

  always @(posedge iCLK) begin
    if (!oSTB || iACK) stb_cnt <= 0;
    else               stb_cnt <= stb_cnt + 1;
  end

  assign iACK = oSTB && (stb_cnt == ack_delay) && (oADR != noack_adr);

  always_comb begin
    iDAT = 32'hDEAD_BEEF;
    case (oADR)
      32'h0200_0100: iDAT = 32'h0123_4567;
      32'h0200_0104: iDAT = 32'h89AB_CDEF;
      32'h0200_0108: iDAT = 32'hFEDC_BA98;
      default:       iDAT = 32'hDEAD_BEEF;
    endcase
    if (oADR == bad_adr) iDAT = bad_val;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Pulse start, then follow the run to oDONE. Returns edges from the start
  // edge to the edge raising oDONE, strobe cycles seen, and the number of
  // cycles with a wrong address/oWE.
  task automatic run(output int edges, output int stbc, output int adr_bad);
    int   k;
    logic prev_stb;
    @(negedge iCLK) iSTART = 1'b1;
    @(posedge iCLK);
    #1 iSTART = 1'b0;
    edges = 0; stbc = 0; adr_bad = 0; k = 0; prev_stb = 1'b0;
    while (!oDONE && edges < 200) begin
      if (prev_stb && !oSTB) k++;
      if (oSTB) begin
        stbc++;
        if (oADR !== 32'h0200_0100 + 32'(4 * k)) adr_bad++;
      end else if (oADR !== 32'd0) adr_bad++;
      if (oWE !== 1'b0) adr_bad++;
      prev_stb = oSTB;
      @(posedge iCLK); #1;
      edges++;
    end
  endtask

  typedef struct {
    string       name;
    int          delay;
    logic [31:0] noack;
    logic [31:0] badadr;
    logic [31:0] badval;
    logic        pass;
    logic        tmo;
    logic [1:0]  err;
    logic [31:0] last;
    int          edges;
    int          stbc;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int edges, stbc, adr_bad, dones;
    // name delay noack badadr badval pass tmo err last edges stbc
    vecs[0] = '{"pass_fast",   0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 2'd0, 32'hFEDC_BA98,  5,  3};
    vecs[1] = '{"mismatch1",   0, 32'hFFFF_FFFF, 32'h0200_0104, 32'h0, 1'b0, 1'b0, 2'd1, 32'h0000_0000,  3,  2};
    vecs[2] = '{"timeout2",    0, 32'h0200_0108, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1, 2'd2, 32'h89AB_CDEF, 12, 10};
    vecs[3] = '{"pass_delay3", 3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 2'd0, 32'hFEDC_BA98, 14, 12};
    vecs[4] = '{"mismatch0",   0, 32'hFFFF_FFFF, 32'h0200_0100, 32'h0123_4566, 1'b0, 1'b0, 2'd0, 32'h0123_4566, 1, 1};
    vecs[5] = '{"timeout0",    0, 32'h0200_0100, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1, 2'd0, 32'h0000_0000,  8,  8};
    vecs[6] = '{"mismatch2_d2",2, 32'hFFFF_FFFF, 32'h0200_0108, 32'hFEDC_BA99, 1'b0, 1'b0, 2'd2, 32'hFEDC_BA99, 11, 9};

    // Reset state
    iRST = 1'b1;
    #12;
    check("rst_stb",  {31'd0, oSTB}, 32'd0);
    check("rst_adr",  oADR, 32'd0);
    check("rst_busy", {31'd0, oBUSY}, 32'd0);
    check("rst_done", {31'd0, oDONE}, 32'd0);
    check("rst_pass", {31'd0, oPASS}, 32'd0);
    check("rst_tmo",  {31'd0, oTIMEOUT}, 32'd0);
    check("rst_err",  {30'd0, oERR_IDX}, 32'd0);
    check("rst_last", oLAST_DAT, 32'd0);
    @(negedge iCLK) iRST = 1'b0;

    foreach (vecs[i]) begin
      ack_delay = vecs[i].delay;
      noack_adr = vecs[i].noack;
      bad_adr   = vecs[i].badadr;
      bad_val   = vecs[i].badval;
      run(edges, stbc, adr_bad);
      check({vecs[i].name, "_edges"}, 32'(edges), 32'(vecs[i].edges));
      check({vecs[i].name, "_stb"},   32'(stbc),  32'(vecs[i].stbc));
      check({vecs[i].name, "_adr"},   32'(adr_bad), 32'd0);
      check({vecs[i].name, "_pass"},  {31'd0, oPASS}, {31'd0, vecs[i].pass});
      check({vecs[i].name, "_tmo"},   {31'd0, oTIMEOUT}, {31'd0, vecs[i].tmo});
      check({vecs[i].name, "_err"},   {30'd0, oERR_IDX}, {30'd0, vecs[i].err});
      check({vecs[i].name, "_last"},  oLAST_DAT, vecs[i].last);
      @(posedge iCLK); #1;
      check({vecs[i].name, "_idle"},  {30'd0, oBUSY, oDONE}, 32'd0);
      // Results hold after completion
      repeat (2) @(posedge iCLK); #1;
      check({vecs[i].name, "_hold"},  {oLAST_DAT[29:0], oPASS, oTIMEOUT},
            {vecs[i].last[29:0], vecs[i].pass, vecs[i].tmo});
    end

    // Start re-pulsed while busy: ignored, exactly one completion
    ack_delay = 1; noack_adr = 32'hFFFF_FFFF; bad_adr = 32'hFFFF_FFFF;
    dones = 0;
    @(negedge iCLK) iSTART = 1'b1;
    @(negedge iCLK) iSTART = 1'b0;
    @(negedge iCLK) iSTART = 1'b1;
    @(negedge iCLK) iSTART = 1'b0;
    for (int c = 0; c < 25; c++) begin
      @(posedge iCLK); #1;
      if (oDONE) dones++;
    end
    check("busy_start_dones", 32'(dones), 32'd1);
    check("busy_start_pass",  {31'd0, oPASS}, 32'd1);

    // Reset asserted in the middle of a strobe
    ack_delay = 3;
    @(negedge iCLK) iSTART = 1'b1;
    @(posedge iCLK); #1 iSTART = 1'b0;
    @(posedge iCLK); #3 iRST = 1'b1;
    #1;
    check("midrst_stb",  {31'd0, oSTB}, 32'd0);
    check("midrst_adr",  oADR, 32'd0);
    check("midrst_busy", {31'd0, oBUSY}, 32'd0);
    check("midrst_res",  {28'd0, oPASS, oTIMEOUT, oERR_IDX}, 32'd0);
    check("midrst_last", oLAST_DAT, 32'd0);
    @(negedge iCLK) iRST = 1'b0;

    // A fresh run after reset passes
    ack_delay = 0;
    run(edges, stbc, adr_bad);
    check("after_rst_edges", 32'(edges), 32'd5);
    check("after_rst_pass",  {31'd0, oPASS}, 32'd1);
    check("after_rst_last",  oLAST_DAT, 32'hFEDC_BA98);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
